// File: rtl/nes_pkg.sv
// Shared NES system definitions: memory map, DMA addresses, OAM DMA state type.
package nes_pkg;

  // CPU-visible memory map, also used by the system bus decoder
  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] RAM_END     = 16'h1FFF;
  localparam logic [15:0] PPU_BASE    = 16'h2000;
  localparam logic [15:0] PPU_END     = 16'h3FFF;
  localparam logic [15:0] APU_IO_BASE = 16'h4000;
  localparam logic [15:0] APU_IO_END  = 16'h401F;
  localparam logic [15:0] PRG_BASE    = 16'h8000;

  // Sprite DMA trigger register and the PPU OAM data port it feeds
  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_PORT = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } oam_dma_state_t;

  // A CPU write cycle to the trigger register starts a sprite DMA
  function automatic logic is_dma_trigger(input logic [15:0] a, input logic r_nw);
    return (a == DMA_REG) && !r_nw;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: on a write to $4014 it stalls the CPU and copies one
// 256-byte page to the PPU OAM data port as read/write pairs. When idle it
// passes the CPU bus straight through.
module oam_dma
  import nes_pkg::*;
(
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        r_nw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  oam_dma_state_t state_q, state_d;
  logic [7:0]     page_q, page_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     data_q, data_d;
  logic           par_q, par_d;
  logic           cpu_rdy_q, cpu_rdy_d;
  logic           dma_active_q, dma_active_d;

  // State, datapath and registered status flops; reset abandons any transfer
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      data_q       <= 8'h00;
      par_q        <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      par_q        <= par_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
    end
  end

  // Next-state and datapath updates; status flags decode the next state so
  // they line up with the state they describe
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = ~par_q;
    case (state_q)
      IDLE: begin
        if (is_dma_trigger(cpu_addr, cpu_r_nw)) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // CPU only actually stops on a read; the pair must start on par==0
        if (cpu_r_nw) begin
          state_d = par_q ? READ : ALIGN;
        end
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        data_d  = bus_din;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cpu_rdy_d    = (state_d == IDLE);
    dma_active_d = (state_d == ALIGN) || (state_d == READ) || (state_d == WRITE);
  end

  // Bus mux: CPU pass-through unless the DMA owns the bus
  always_comb begin
    addr = cpu_addr;
    dout = cpu_dout;
    r_nw = cpu_r_nw;
    case (state_q)
      ALIGN, READ: begin
        addr = {page_q, idx_q};
        dout = data_q;
        r_nw = 1'b1;
      end
      WRITE: begin
        addr = OAM_PORT;
        dout = data_q;
        r_nw = 1'b0;
      end
      default: begin
        addr = cpu_addr;
        dout = cpu_dout;
        r_nw = cpu_r_nw;
      end
    endcase
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = dma_active_q;

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA engine between the 6502 CPU core and the NES system bus. A CPU write to $4014 with value V halts the CPU through `cpu_rdy`, takes over the bus, and copies the 256 bytes at $VV00–$VVFF to the PPU OAM data port $2004 as 256 read/write pairs. Afterwards it releases the bus and the CPU resumes. When idle, the block is a transparent pass-through for the CPU's address, data-out and R/W lines.

## Interface
- `DMA_REG`, 16'h4014: trigger register address
- `OAM_PORT`, 16'h2004: destination address for every DMA write
- `clk_ph1`  in  1  sole clock (CPU phase-1 clock); `clk_ph2` is not used
- `rst`  in  1  asynchronous, active-low reset
- `cpu_addr`  in  16  CPU `Addr_bus`
- `cpu_dout`  in  8  CPU `Data_bus_out`
- `cpu_r_nw`  in  1  CPU `R_nW` (1 = read)
- `bus_din`  in  8  read data returned by the system bus
- `addr`  out  16  system-bus address
- `dout`  out  8  system-bus write data
- `r_nw`  out  1  system-bus read/write
- `cpu_rdy`  out  1  to CPU; 0 stalls the CPU on its next read cycle
- `dma_active`  out  1  high while the DMA owns the bus (ALIGN, READ, WRITE)

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - `page[7:0]`, `idx[7:0]`, `data[7:0]`
  - `par`: free-running toggle flop, inverts every clock from reset
  - `state`
- IDLE:
  - `addr`/`dout`/`r_nw` combinationally equal the CPU's signals; `cpu_rdy`=1.
  - If `cpu_addr`==DMA_REG and `cpu_r_nw`==0: latch `page`=`cpu_dout`, `idx`=0, go to HALT.
- HALT:
  - `cpu_rdy`=0; bus still passes the CPU through, because the 6502 finishes any write in progress.
  - If `cpu_r_nw`==1 (CPU now stalled on a read): go to READ if `par`==1, otherwise go to ALIGN.
  - If `cpu_r_nw`==0: stay in HALT.
- ALIGN: `cpu_rdy`=0; the DMA drives the bus with a dummy read of {`page`,`idx`}; go to READ.
- READ:
  - Only entered when `par`==0.
  - Drive `addr`={`page`,`idx`}, `r_nw`=1; capture `bus_din` into `data` at the clock edge; go to WRITE.
- WRITE:
  - Drive `addr`=OAM_PORT, `dout`=`data`, `r_nw`=0; `idx`<=`idx`+1 (8-bit, wraps).
  - If `idx` was 8'hFF: go to IDLE. Otherwise go to READ.
- While the DMA owns the bus, `dout`=`data` (value is don't-care on reads).
- A write to DMA_REG outside IDLE is ignored; the CPU is stalled, so this only arises from a write that completes in HALT.
- `irq`/`nmi` are not handled here; they stay pending in the CPU across the DMA.

## Timing
- Reset (async, `rst`=0):
  - `state`=IDLE, `cpu_rdy`=1, `dma_active`=0, `par`=0, `page`=`idx`=`data`=0.
  - `addr`/`dout`/`r_nw` follow the CPU.
- Reset asserted mid-transfer: the transfer is abandoned immediately; OAM keeps the bytes already written.
- `cpu_rdy` and `dma_active` are registered (decoded from `state`). The bus mux is combinational from `state`.
- Cycle numbering: T0 is the CPU write to $4014.
  - T1 is HALT.
  - Without ALIGN: READ i at T2+2i, WRITE i at T3+2i, last write at T513, IDLE with `cpu_rdy`=1 at T514 (total 513 stall cycles).
  - With ALIGN (CPU read in T1 with `par`=0): everything shifts +1, giving 514 stall cycles.
- Each extra CPU write cycle after T0 extends HALT by one cycle.
- The destination is always $2004; $2003 (OAMADDR) is never touched.

## Structure
- Shared package `nes_pkg` holds:
  - `DMA_REG` and `OAM_PORT` constants
  - the `oam_dma_state_t` enum {IDLE, HALT, ALIGN, READ, WRITE}
  - the memory-map constants also used by the bus decoder
- No sub-module; the bus mux stays inline.
- The block sits between the `CPU` outputs and the address decoder. `cpu_rdy` feeds the CPU's RDY input.

## Test plan
- Reset, then CPU reads $0000 → `addr`=16'h0000, `r_nw`=1, `cpu_rdy`=1, `dma_active`=0. Assert `rst` low mid-transfer → IDLE in the same cycle.
- Preload $0200+i=i^8'h5A. Write 8'h02 to $4014 with CPU reading in T1 and `par`=1 → 256 writes to $2004 with data 8'h5A, 8'h5B, …, 8'hA5; `cpu_rdy` returns to 1 at T514.
- Same transfer with `par`=0 at T1 → one ALIGN cycle; `cpu_rdy` returns at T515.
- Trigger via STA followed by two further CPU write cycles (emulated PHA/PHP-style writes) → HALT lasts 3 cycles, and those writes reach the bus unaltered.
- Page 8'hFF → reads $FF00–$FFFF; `idx` wraps to 0 with no carry into `page`; exactly 256 writes.
- Write 8'h07 to $4015 and read $4014 → no DMA starts, `cpu_rdy` stays 1.
